// File: rtl/piso_tx_pkg.sv
// Shared state and output-phase types for the PISO transmit controller.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_PARITY
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_DATA,
    PH_PARITY
  } phase_t;

endpackage

// File: rtl/piso_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
// The pointer only moves when the grant is actually consumed (advance).
module piso_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       Clk,
  input  logic                       Rst_l,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr_reg;
  logic [IW:0]   cand;
  logic          found;

  // One extra bit on cand so ptr+k cannot overflow before the modulo fold.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi = gi + 1) begin : g_grant
      assign grant[gi] = found && (grant_idx == IW'(gi));
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Rst_l)
      ptr_reg <= '0;
    else if (advance && found)
      ptr_reg <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
  end

endmodule

// File: rtl/piso_tx_ctrl.sv
// PISO transmit controller: round-robin word intake, shift-register sequencing, framed serial out.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2
) (
  input  logic                       Clk,
  input  logic                       Rst_l,
  input  logic [NUM_REQ-1:0]         Req_Valid,
  input  logic [NUM_REQ*WIDTH-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]         Req_Ready,
  output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
  output logic                       Shift_LD,
  output logic [WIDTH-1:0]           Par_Data,
  input  logic                       Ser_In,
  output logic                       Tx_Data,
  output logic                       Tx_Valid,
  output logic                       Frame_Done,
  output logic                       Busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  phase_t           phase_reg;
  logic             shift_ld_reg;
  logic [WIDTH-1:0] par_data_reg;
  logic [IW-1:0]    grant_id_reg;
  logic             tx_data_reg;
  logic             frame_done_reg;
  logic [CW-1:0]    bit_cnt_reg;

  logic [WIDTH-1:0]   req_word [NUM_REQ];
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi = gi + 1) begin : g_unpack
      assign req_word[gi] = Req_Data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign accept = (state_reg == ST_IDLE) && (|Req_Valid);

  piso_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk       (Clk),
    .Rst_l     (Rst_l),
    .req       (Req_Valid),
    .advance   (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Phase and Tx_Data lag the state by one cycle, matching the shift register's
  // Serial_Out which only presents a new bit after each shift edge.
  always_ff @(posedge Clk) begin
    if (!Rst_l) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= PH_NONE;
      shift_ld_reg   <= 1'b1;
      par_data_reg   <= '0;
      grant_id_reg   <= '0;
      tx_data_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      bit_cnt_reg    <= '0;
    end else begin
      shift_ld_reg   <= 1'b1;
      phase_reg      <= PH_NONE;
      tx_data_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            par_data_reg <= req_word[arb_idx];
            grant_id_reg <= arb_idx;
            shift_ld_reg <= 1'b0;
            state_reg    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bit_cnt_reg <= '0;
          state_reg   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          phase_reg   <= PH_DATA;
          tx_data_reg <= Ser_In;
          bit_cnt_reg <= bit_cnt_reg + CW'(1);
          if (bit_cnt_reg == CW'(WIDTH - 1)) begin
`ifdef PISO_TX_PARITY_EN
            state_reg <= ST_PARITY;
`else
            frame_done_reg <= 1'b1;
            state_reg      <= ST_IDLE;
`endif
          end
        end
`ifdef PISO_TX_PARITY_EN
        ST_PARITY: begin
          phase_reg      <= PH_PARITY;
          tx_data_reg    <= ^par_data_reg;
          frame_done_reg <= 1'b1;
          state_reg      <= ST_IDLE;
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Req_Ready  = (state_reg == ST_IDLE) ? arb_grant : '0;
  assign Grant_Id   = grant_id_reg;
  assign Shift_LD   = shift_ld_reg;
  assign Par_Data   = par_data_reg;
  assign Tx_Data    = tx_data_reg;
  assign Tx_Valid   = (phase_reg != PH_NONE);
  assign Frame_Done = frame_done_reg;
  assign Busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl with a behavioural MSB-first shift register attached.
// Honours PISO_TX_PARITY_EN for the expected frame length and parity bit.
module tb_piso_tx_ctrl;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 2;
  localparam int IW      = $clog2(NUM_REQ);
`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic                     Clk = 1'b0;
  logic                     Rst_l = 1'b0;
  logic [NUM_REQ-1:0]       Req_Valid = '0;
  logic [NUM_REQ*WIDTH-1:0] Req_Data = '0;
  logic [NUM_REQ-1:0]       Req_Ready;
  logic [IW-1:0]            Grant_Id;
  logic                     Shift_LD;
  logic [WIDTH-1:0]         Par_Data;
  logic                     Ser_In;
  logic                     Tx_Data;
  logic                     Tx_Valid;
  logic                     Frame_Done;
  logic                     Busy;
  logic [WIDTH-1:0]         sr_q = '0;

  piso_tx_ctrl #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .Clk        (Clk),
    .Rst_l      (Rst_l),
    .Req_Valid  (Req_Valid),
    .Req_Data   (Req_Data),
    .Req_Ready  (Req_Ready),
    .Grant_Id   (Grant_Id),
    .Shift_LD   (Shift_LD),
    .Par_Data   (Par_Data),
    .Ser_In     (Ser_In),
    .Tx_Data    (Tx_Data),
    .Tx_Valid   (Tx_Valid),
    .Frame_Done (Frame_Done),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // External shift register: load when Shift_LD=0, else shift left; MSB is Serial_Out.
  always @(posedge Clk) sr_q <= Shift_LD ? {sr_q[WIDTH-2:0], 1'b0} : Par_Data;
  assign Ser_In = sr_q[WIDTH-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int next_ok = 0;
  int last_acc = -100;
  int rr_m = 0;
  int n_acc = 0;
  int acc_val = 0;
  int acc_len = 0;
  int exp_gid = 0;
  bit gid_due = 1'b0;
  bit refill = 1'b0;
  bit pend [NUM_REQ];
  logic [WIDTH-1:0] word [NUM_REQ];
  int exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame as an integer, first transmitted bit most significant.
  function automatic int frame_val(input logic [WIDTH-1:0] w);
`ifdef PISO_TX_PARITY_EN
    return int'(w) * 2 + ($countones(w) % 2);
`else
    return int'(w);
`endif
  endfunction

  // One clock cycle: sample registered outputs, drive requesters, predict the
  // arbitration outcome from the round-robin rule and frame timing, then advance.
  task automatic cycle();
    int win;
    int exp_v;
    logic [NUM_REQ-1:0] exp_rdy;
    chk("busy", Busy, (cyc > last_acc && cyc < next_ok) ? 1 : 0);
    if (gid_due) begin
      chk("grant_id", Grant_Id, exp_gid);
      gid_due = 1'b0;
    end
    if (Tx_Valid) begin
      acc_val = acc_val * 2 + int'(Tx_Data);
      acc_len++;
    end
    if (Frame_Done) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("done_with_valid", Tx_Valid, 1);
      chk("frame_bits", acc_val, exp_v);
      chk("frame_len", acc_len, FL);
      $display("t=%0t frame bits=%0h len=%0d expected=%0h", $time, acc_val, acc_len, exp_v);
      acc_val = 0;
      acc_len = 0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      Req_Valid[i] = pend[i];
      Req_Data[i*WIDTH +: WIDTH] = word[i];
    end
    win = -1;
    if (cyc >= next_ok)
      for (int k = 0; k < NUM_REQ; k++)
        if (win < 0 && pend[(rr_m + k) % NUM_REQ]) win = (rr_m + k) % NUM_REQ;
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    #1;
    chk("req_ready", Req_Ready, exp_rdy);
    if (win >= 0) begin
      $display("t=%0t accept req=%0d word=%0h", $time, win, word[win]);
      exp_q.push_back(frame_val(word[win]));
      exp_gid  = win;
      gid_due  = 1'b1;
      rr_m     = (win + 1) % NUM_REQ;
      last_acc = cyc;
      next_ok  = cyc + 2 + FL;
      n_acc++;
      if (!refill) pend[win] = 1'b0;
    end
    cyc++;
    @(negedge Clk);
  endtask

  initial begin
    int start;
    int f;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      word[i] = '0;
    end

    // Reset held for two cycles.
    Rst_l = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_shift_ld", Shift_LD, 1);
    chk("rst_tx_valid", Tx_Valid, 0);
    chk("rst_req_ready", Req_Ready, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_grant_id", Grant_Id, 0);
    Rst_l = 1'b1;

    // Single word 1011 from requester 0: exact latency and bit order.
    pend[0] = 1'b1;
    word[0] = 4'b1011;
    f = frame_val(word[0]);
    cycle();
    chk("load_shift_ld", Shift_LD, 0);
    for (int c = 1; c <= FL + 3; c++) begin
      chk("lat_valid", Tx_Valid, (c >= 3 && c <= 2 + FL) ? 1 : 0);
      chk("lat_data", Tx_Data, (c >= 3 && c <= 2 + FL) ? ((f >> (FL - 1 - (c - 3))) & 1) : 0);
      chk("lat_done", Frame_Done, (c == 2 + FL) ? 1 : 0);
      cycle();
    end

    // Requester 1 raises valid mid-frame: no ready until the FSM is idle.
    pend[0] = 1'b1;
    word[0] = WIDTH'($urandom);
    cycle();
    cycle();
    pend[1] = 1'b1;
    word[1] = WIDTH'($urandom);
    start = n_acc;
    for (int i = 0; i < 40 && n_acc == start; i++) cycle();
    chk("late_req_granted", n_acc, start + 1);
    repeat (FL + 4) cycle();

    // Both requesters held valid: grants alternate 0,1,0,1.
    refill  = 1'b1;
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    word[0] = 4'hA;
    word[1] = 4'h5;
    start = n_acc;
    for (int i = 0; i < 100 && n_acc < start + 4; i++) cycle();
    chk("alt_grants", n_acc, start + 4);
    refill  = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (FL + 4) cycle();

    // Parity corner words 0 and 7.
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    word[0] = 4'h0;
    word[1] = 4'h7;
    start = n_acc;
    for (int i = 0; i < 60 && n_acc < start + 2; i++) cycle();
    chk("parity_words", n_acc, start + 2);
    repeat (FL + 4) cycle();

    // Reset during SHIFT bit 2 while both requesters wait.
    pend[0] = 1'b1;
    word[0] = WIDTH'($urandom);
    cycle();
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    word[0] = WIDTH'($urandom);
    word[1] = WIDTH'($urandom);
    repeat (3) cycle();
    Rst_l = 1'b0;
    @(negedge Clk);
    cyc++;
    chk("abort_tx_valid", Tx_Valid, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Frame_Done, 0);
    Rst_l = 1'b1;
    exp_q.delete();
    acc_val = 0;
    acc_len = 0;
    gid_due = 1'b0;
    rr_m    = 0;
    next_ok = cyc;
    start = n_acc;
    cycle();
    chk("regrant_after_rst", n_acc, start + 1);
    for (int i = 0; i < 60 && n_acc < start + 2; i++) cycle();
    repeat (FL + 4) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!pend[r] && $urandom_range(0, 3) == 0) begin
          pend[r] = 1'b1;
          word[r] = WIDTH'($urandom);
        end
      cycle();
    end
    for (int r = 0; r < NUM_REQ; r++) pend[r] = 1'b0;
    repeat (FL + 4) cycle();
    chk("frames_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
